axis_tx_seq_ctrl: RTL and testbench
===================================

Name: axis_tx_seq_ctrl

Overview:
- Transmit end of the character-stream path: mirror of the input stream controller.
- Accepts complete N-character sequences from the core as one parallel word per handshake and buffers up to DEPTH sequences.
- Serialises each buffered sequence onto the AXI Stream master port, one character per beat, with TLAST on the final character of every sequence.
- Sits between the comp/output stage of top and M_AXIS_*; the host reads one TLAST-delimited packet per sequence.

Parameters:
- CHAR_LEN, 8: width of one character / TDATA.
- N, 10: characters per sequence (beats per packet), N >= 2.
- DEPTH, 4: sequence buffer entries, power of 2, >= 2.
- CNT_W, 16: width of the sent-sequence counter.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush, active high.
- d_data  in  N*CHAR_LEN  sequence; char k at bits [k*CHAR_LEN +: CHAR_LEN], char 0 sent first.
- d_valid  in  1  d_data valid.
- d_ready  out  1  buffer can accept a sequence.
- M_AXIS_TDATA  out  CHAR_LEN  current character.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TLAST  out  1  last beat of sequence.
- M_AXIS_TREADY  in  1  downstream ready.
- count  out  $clog2(DEPTH)+1  sequences buffered, including the one in flight.
- seq_cnt  out  CNT_W  sequences fully sent; wraps at 2^CNT_W.

Behaviour:
- Reset (ARESETN=0, async): wr_ptr=0, rd_ptr=0, beat index idx=0, count=0, seq_cnt=0. Outputs: d_ready=1, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0. Buffer contents are don't-care.
- Push: occurs on d_valid && d_ready. d_data is written to mem[wr_ptr] and wr_ptr increments mod DEPTH.
- d_ready = (count != DEPTH). It is a combinational function of registers only and never depends on TREADY, so a full buffer never passes data through in the same cycle.
- Read side states:
  - IDLE (count==0): TVALID=0, TLAST=0, TDATA=0.
  - SEND (count>0): TVALID=1, TDATA=mem[rd_ptr][idx*CHAR_LEN +: CHAR_LEN], TLAST=(idx==N-1).
  - All three outputs are driven only from registers and the memory.
- Latency: a push into an empty buffer at edge t gives TVALID=1 with char 0 in the cycle after t. There is no same-cycle bypass.
- Beat transfer occurs on TVALID && TREADY:
  - idx<N-1: idx increments.
  - idx==N-1: idx returns to 0, rd_ptr increments, count decrements, seq_cnt increments.
- Back-to-back sequences: if count>1 when the last beat transfers, the next cycle presents char 0 of the next entry with TVALID held at 1 (no bubble).
- Stall: while TVALID=1 and TREADY=0, TDATA, TLAST and idx stay stable. TVALID never falls without a transfer, except on clr or reset.
- Simultaneous push and final-beat pop: count is unchanged. This is legal even at count==DEPTH only if d_ready was already 1; d_ready is evaluated before the pop.
- clr:
  - Next edge: ptrs, idx and count go to 0, and TVALID drops. seq_cnt is kept.
  - clr has priority over a simultaneous push or pop; both are discarded.
  - clr is an abort and may truncate a packet mid-sequence; the host re-synchronises on the next TLAST.
- Reset mid-packet: same effect as clr, plus seq_cnt=0.
- Pointer wrap: rd_ptr and wr_ptr wrap DEPTH-1 -> 0. Full vs empty is distinguished by count, not by pointer equality.

Test Plan (N=10, CHAR_LEN=8, DEPTH=4):
- Single sequence:
  - Stimulus: reset, push d_data with char k = 8'h30+k, TREADY=1.
  - Response: TVALID rises the cycle after the push; 10 consecutive beats 30..39; TLAST only on 39; then TVALID=0, seq_cnt=1, count=0.
- Fill and backpressure:
  - Stimulus: TREADY=0, push 5 sequences back-to-back.
  - Response: 4 accepted; d_ready=0 after the 4th; count=4; TDATA=char 0 of seq 0 held stable across 20 stalled cycles.
- Drain without bubbles:
  - Stimulus: from the full state, TREADY=1.
  - Response: 40 beats with TVALID continuously 1; TLAST at beats 9, 19, 29, 39; chars are in order; seq_cnt=4.
- Random TREADY:
  - Stimulus: 50% TREADY while pushing 8 sequences, forcing pointer wrap.
  - Response: the received byte stream equals the pushed data in order; no beat is lost or duplicated; TLAST count is 8.
- Simultaneous push and pop at count==3:
  - Stimulus: push on the same edge as the last-beat transfer.
  - Response: count stays 3; the next cycle shows char 0 of the following entry.
- clr mid-packet:
  - Stimulus: assert clr after beat 4 of seq 0, with 2 sequences queued and a push on the same edge.
  - Response: next cycle TVALID=0, count=0, d_ready=1, seq_cnt unchanged; the push is dropped; a subsequent push is sent starting at char 0.

Source files
------------

// File: rtl/axis_tx_seq_ctrl_if.sv
// Handshake bundle for the transmit sequence controller: the parallel
// sequence input from the core and the AXI Stream master output.
// The master modport is the controller's view; slave is the environment's view.
interface axis_tx_seq_ctrl_if #(
  parameter int CHAR_LEN = 8,
  parameter int N        = 10
);
  logic [N*CHAR_LEN-1:0] d_data;
  logic                  d_valid;
  logic                  d_ready;
  logic [CHAR_LEN-1:0]   M_AXIS_TDATA;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TLAST;
  logic                  M_AXIS_TREADY;

  modport master (
    input  d_data, d_valid, M_AXIS_TREADY,
    output d_ready, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
  );

  modport slave (
    output d_data, d_valid, M_AXIS_TREADY,
    input  d_ready, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
  );
endinterface

// File: rtl/axis_tx_seq_ctrl.sv
// Transmit sequence controller: buffers up to DEPTH whole N-character
// sequences and serialises each one onto AXI Stream, one character per beat,
// with TLAST on the final character. Output stage is a pure function of
// registers and the buffer, so there is no input-to-output combinational path.
module axis_tx_seq_ctrl #(
  parameter int CHAR_LEN = 8,
  parameter int N        = 10,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   clr,
  axis_tx_seq_ctrl_if.master     bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       seq_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(N);
  localparam int SEQ_W = N * CHAR_LEN;

  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] SEQ_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [SEQ_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CW-1:0]      count_r;
  logic [CNT_W-1:0]   seq_cnt_r;

  logic               ready_s;
  logic               push_s;
  logic               beat_s;
  logic               last_s;
  logic               tvalid_s;
  logic               tlast_s;
  logic [CHAR_LEN-1:0] tdata_s;
  logic [SEQ_W-1:0]   cur_seq_s;

  // Next-state and read-side output decode; clr discards any push or pop.
  always_comb begin
    state_s   = state_r;
    tvalid_s  = 1'b0;
    tlast_s   = 1'b0;
    tdata_s   = '0;
    beat_s    = 1'b0;
    last_s    = 1'b0;
    cur_seq_s = mem_r[rd_ptr_r];
    ready_s   = (count_r != CNT_FULL);
    push_s    = bus.d_valid && ready_s && !clr;
    case (state_r)
      ST_IDLE: begin
        if (clr) begin
          state_s = ST_IDLE;
        end else if (push_s) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        tvalid_s = 1'b1;
        tdata_s  = cur_seq_s[idx_r*CHAR_LEN +: CHAR_LEN];
        tlast_s  = (idx_r == IDX_LAST);
        beat_s   = bus.M_AXIS_TREADY && !clr;
        last_s   = beat_s && tlast_s;
        if (clr) begin
          state_s = ST_IDLE;
        end else if (last_s && (count_r == CNT_ONE) && !push_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequence buffer write port; contents are not cleared by clr.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= bus.d_data;
    end
  end

  // Control state: FSM, pointers, beat index, occupancy and sent counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r   <= ST_IDLE;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      idx_r     <= '0;
      count_r   <= '0;
      seq_cnt_r <= '0;
    end else if (clr) begin
      state_r   <= ST_IDLE;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      idx_r     <= '0;
      count_r   <= '0;
    end else begin
      state_r <= state_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (last_s) begin
        idx_r     <= '0;
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        seq_cnt_r <= seq_cnt_r + SEQ_ONE;
      end else if (beat_s) begin
        idx_r <= idx_r + IDX_ONE;
      end
      case ({push_s, last_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.d_ready       = ready_s;
  assign bus.M_AXIS_TVALID = tvalid_s;
  assign bus.M_AXIS_TLAST  = tlast_s;
  assign bus.M_AXIS_TDATA  = tdata_s;
  assign count             = count_r;
  assign seq_cnt           = seq_cnt_r;

endmodule

// File: tb/tb_axis_tx_seq_ctrl.sv
// Self-checking bench for axis_tx_seq_ctrl: expected beats are queued when a
// sequence is accepted and compared by a monitor as beats leave the DUT.
module tb_axis_tx_seq_ctrl;
  localparam int CL = 8;
  localparam int NC = 10;
  localparam int DP = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [$clog2(DP):0] count;
  logic [CW-1:0] seq_cnt;

  axis_tx_seq_ctrl_if #(.CHAR_LEN(CL), .N(NC)) bus ();

  axis_tx_seq_ctrl #(.CHAR_LEN(CL), .N(NC), .DEPTH(DP), .CNT_W(CW)) dut (
    .ACLK(clk), .ARESETN(rst_n), .clr(clr), .bus(bus),
    .count(count), .seq_cnt(seq_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tlast_cnt = 0;
  logic [CL:0] sb_q[$];

  function automatic logic [NC*CL-1:0] mk_seq(input logic [CL-1:0] base);
    logic [NC*CL-1:0] s;
    s = '0;
    for (int k = 0; k < NC; k++) s[k*CL +: CL] = base + 8'(k);
    return s;
  endfunction

  // Scoreboard monitor: a beat transfers at the next rising edge.
  always @(negedge clk) begin
    logic [CL:0] exp_b;
    if (rst_n && !clr && bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
      n_tests++;
      if (bus.M_AXIS_TLAST) tlast_cnt++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_beat got=%h expected=none", {bus.M_AXIS_TLAST, bus.M_AXIS_TDATA});
      end else begin
        exp_b = sb_q.pop_front();
        if ({bus.M_AXIS_TLAST, bus.M_AXIS_TDATA} !== exp_b) begin
          n_fail++;
          $display("FAIL sb_beat got=%h expected=%h", {bus.M_AXIS_TLAST, bus.M_AXIS_TDATA}, exp_b);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Offer one sequence; enqueue its beats when accepted. Ends at posedge+1.
  task automatic push_seq(input logic [NC*CL-1:0] data);
    bit ok = 1'b0;
    bus.d_valid = 1'b1;
    bus.d_data  = data;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus.d_ready && !clr) begin
        ok = 1'b1;
        for (int k = 0; k < NC; k++) sb_q.push_back({(k == NC-1), data[k*CL +: CL]});
      end
      @(posedge clk); #1;
    end
    bus.d_valid = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_timeout got=not_accepted expected=accepted");
    end
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 1000 && (sb_q.size() != 0 || count != 0); t++) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0 || count !== 0) begin
      n_fail++;
      $display("FAIL %s_drain got=q%0d/c%0d expected=q0/c0", name, sb_q.size(), count);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.d_ready, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST} !== 3'b100 || bus.M_AXIS_TDATA !== 8'h00
        || count !== 3'd0 || seq_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state got=rdy%b v%b l%b d%h c%0d s%0d expected=rdy1 v0 l0 d00 c0 s0",
               bus.d_ready, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST, bus.M_AXIS_TDATA, count, seq_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    bus.M_AXIS_TREADY = 1'b1;
    push_seq(mk_seq(8'h30));
    n_tests++;
    if (bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TDATA !== 8'h30) begin
      n_fail++;
      $display("FAIL single_latency got=v%b d%h expected=v1 d30", bus.M_AXIS_TVALID, bus.M_AXIS_TDATA);
    end
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TDATA !== 8'(8'h30 + i) || bus.M_AXIS_TLAST !== (i == NC-1)) begin
        n_fail++;
        $display("FAIL single_beat%0d got=v%b d%h l%b expected=v1 d%h l%b", i, bus.M_AXIS_TVALID,
                 bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, 8'(8'h30 + i), (i == NC-1));
      end
    end
    @(negedge clk);
    n_tests++;
    if (bus.M_AXIS_TVALID !== 1'b0 || seq_cnt !== 16'd1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_end got=v%b s%0d c%0d expected=v0 s1 c0", bus.M_AXIS_TVALID, seq_cnt, count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_and_drain;
    logic [CW-1:0] sc0;
    sc0 = seq_cnt;
    bus.M_AXIS_TREADY = 1'b0;
    for (int s = 0; s < DP; s++) push_seq(mk_seq(8'(8'h40 + 16*s)));
    n_tests++;
    if (bus.d_ready !== 1'b0 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_full got=rdy%b c%0d expected=rdy0 c4", bus.d_ready, count);
    end
    bus.d_valid = 1'b1;
    bus.d_data  = mk_seq(8'h78);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.d_ready !== 1'b0 || bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TDATA !== 8'h40
          || bus.M_AXIS_TLAST !== 1'b0 || count !== 3'd4) begin
        n_fail++;
        $display("FAIL stall%0d got=rdy%b v%b d%h l%b c%0d expected=rdy0 v1 d40 l0 c4", i,
                 bus.d_ready, bus.M_AXIS_TVALID, bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, count);
      end
    end
    @(posedge clk); #1;
    bus.d_valid = 1'b0;
    bus.M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < DP*NC; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TLAST !== ((i % NC) == NC-1)
          || bus.M_AXIS_TDATA !== 8'(8'h40 + 16*(i / NC) + (i % NC))) begin
        n_fail++;
        $display("FAIL drain_beat%0d got=v%b d%h l%b expected=v1 d%h l%b", i, bus.M_AXIS_TVALID,
                 bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, 8'(8'h40 + 16*(i / NC) + (i % NC)), ((i % NC) == NC-1));
      end
    end
    @(negedge clk);
    n_tests++;
    if (bus.M_AXIS_TVALID !== 1'b0 || seq_cnt !== sc0 + 16'd4 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_end got=v%b s%0d c%0d expected=v0 s%0d c0", bus.M_AXIS_TVALID, seq_cnt, count, sc0 + 16'd4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_ready;
    int tl0;
    bit done = 1'b0;
    tl0 = tlast_cnt;
    fork
      begin
        for (int s = 0; s < 8; s++) push_seq(mk_seq(8'($urandom_range(0, 255))));
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !(done && sb_q.size() == 0); c++) begin
          @(posedge clk); #1;
          bus.M_AXIS_TREADY = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.M_AXIS_TREADY = 1'b1;
    wait_drain("random");
    n_tests++;
    if (tlast_cnt - tl0 != 8) begin
      n_fail++;
      $display("FAIL random_tlast got=%0d expected=8", tlast_cnt - tl0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop_same_edge;
    bit seen = 1'b0;
    bus.M_AXIS_TREADY = 1'b0;
    push_seq(mk_seq(8'hB0));
    push_seq(mk_seq(8'hC0));
    push_seq(mk_seq(8'hD0));
    bus.M_AXIS_TREADY = 1'b1;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (bus.M_AXIS_TLAST) seen = 1'b1;
    end
    n_tests++;
    if (!seen || count !== 3'd3 || bus.d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_setup got=last%b c%0d rdy%b expected=last1 c3 rdy1", seen, count, bus.d_ready);
    end
    bus.d_valid = 1'b1;
    bus.d_data  = mk_seq(8'hE0);
    for (int k = 0; k < NC; k++) sb_q.push_back({(k == NC-1), 8'(8'hE0 + k)});
    @(posedge clk); #1;
    bus.d_valid = 1'b0;
    n_tests++;
    if (count !== 3'd3 || bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TDATA !== 8'hC0) begin
      n_fail++;
      $display("FAIL pp_result got=c%0d v%b d%h expected=c3 v1 dc0", count, bus.M_AXIS_TVALID, bus.M_AXIS_TDATA);
    end
    wait_drain("pp");
    @(posedge clk); #1;
  endtask

  task automatic test_clr_mid_packet;
    logic [CW-1:0] sc0;
    sc0 = seq_cnt;
    bus.M_AXIS_TREADY = 1'b0;
    push_seq(mk_seq(8'h80));
    push_seq(mk_seq(8'h90));
    bus.M_AXIS_TREADY = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    bus.d_valid = 1'b1;
    bus.d_data  = mk_seq(8'hF0);
    sb_q.delete();
    @(posedge clk); #1;
    clr = 1'b0;
    bus.d_valid = 1'b0;
    n_tests++;
    if (bus.M_AXIS_TVALID !== 1'b0 || count !== 3'd0 || bus.d_ready !== 1'b1 || seq_cnt !== sc0) begin
      n_fail++;
      $display("FAIL clr_state got=v%b c%0d rdy%b s%0d expected=v0 c0 rdy1 s%0d",
               bus.M_AXIS_TVALID, count, bus.d_ready, seq_cnt, sc0);
    end
    push_seq(mk_seq(8'hA0));
    n_tests++;
    if (bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TDATA !== 8'hA0) begin
      n_fail++;
      $display("FAIL clr_restart got=v%b d%h expected=v1 da0", bus.M_AXIS_TVALID, bus.M_AXIS_TDATA);
    end
    wait_drain("clr");
    n_tests++;
    if (seq_cnt !== sc0 + 16'd1) begin
      n_fail++;
      $display("FAIL clr_seq_cnt got=%0d expected=%0d", seq_cnt, sc0 + 16'd1);
    end
  endtask

  initial begin
    bus.d_valid = 1'b0;
    bus.d_data  = '0;
    bus.M_AXIS_TREADY = 1'b0;
    test_reset();
    test_single();
    test_fill_and_drain();
    test_random_ready();
    test_push_pop_same_edge();
    test_clr_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
